// File: rtl/code_pkg.sv
// Shared constants for the code sender and the sequence lock it drives:
// code geometry, the factory default code, lock status encodings and the
// sender FSM state encodings.
`timescale 1ns/1ps
package code_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;

  // Factory default code, identical to the one hard-wired into the lock.
  localparam logic [DIGIT_W-1:0] D0 = 4'd5;
  localparam logic [DIGIT_W-1:0] D1 = 4'd7;
  localparam logic [DIGIT_W-1:0] D2 = 4'd5;
  localparam logic [DIGIT_W-1:0] D3 = 4'd1;
  localparam logic [DIGIT_W-1:0] D4 = 4'd6;
  localparam logic [DIGIT_W-1:0] D5 = 4'd4;

  // Lock status display encodings.
  localparam logic [1:0] ST_WAIT    = 2'b00;
  localparam logic [1:0] ST_PARTIAL = 2'b01;
  localparam logic [1:0] ST_SUCCESS = 2'b10;
  localparam logic [1:0] ST_ERROR   = 2'b11;

  // Sender FSM states, kept as plain constants for compatibility with
  // existing debug tooling that decodes the raw state value.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LRST = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Outcome of the current or most recent run.
  typedef struct packed {
    logic       success;
    logic       fail;
    logic [1:0] retry_count;
  } result_t;

  // Default digit for a code slot; slots beyond the default code read 0.
  function automatic logic [DIGIT_W-1:0] default_digit(input int slot);
    case (slot)
      0:       return D0;
      1:       return D1;
      2:       return D2;
      3:       return D3;
      4:       return D4;
      5:       return D5;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/code_store.sv
// Programmable code register file: NUM_DIGITS slots of DIGIT_W bits,
// reset to the default code, one guarded write port, async read port.
`timescale 1ns/1ps
module code_store #(
  parameter int NUM_DIGITS = code_pkg::NUM_DIGITS,
  parameter int DIGIT_W    = code_pkg::DIGIT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  logic [DIGIT_W-1:0] wr_digit,
  input  logic [2:0]         rd_idx,
  output logic [DIGIT_W-1:0] rd_digit
);
  import code_pkg::*;

  logic [DIGIT_W-1:0] mem_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] mem_d [NUM_DIGITS];

  // Next-state of the register file: only an existing slot can match
  // wr_idx, so out-of-range indices write nothing.
  always_comb begin
    // NOTE: start from the held value so every path assigns mem_d; a
    // missing default here would infer latches.
    mem_d = mem_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      // NOTE: blocking assignments in combinational logic, non-blocking
      // only in clocked blocks.
      if (wr_en && (wr_idx == 3'(i))) mem_d[i] = wr_digit;
    end
  end

  // Slot registers with reset to the default code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: this is a small flop array, not a RAM macro, so it can and
      // must be reset: the default code has to be present after reset.
      for (int i = 0; i < NUM_DIGITS; i++) mem_q[i] <= DIGIT_W'(default_digit(i));
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous read mux.
  always_comb begin
    rd_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rd_idx == 3'(i)) rd_digit = mem_q[i];
    end
  end

endmodule

// File: rtl/code_sender.sv
// Code sender: replays the stored code into a sequence lock one digit per
// step, watches the lock status and retries a bounded number of times.
`timescale 1ns/1ps
module code_sender #(
  parameter int NUM_DIGITS     = code_pkg::NUM_DIGITS,
  parameter int DIGIT_W        = code_pkg::DIGIT_W,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int MAX_RETRIES    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               load_en,
  input  logic [2:0]         load_idx,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic [1:0]         lock_status,
  output logic [DIGIT_W-1:0] number,
  output logic               number_valid,
  output logic               lock_rst,
  output logic               busy,
  output logic               done,
  output logic               success,
  output logic               fail,
  output logic [1:0]         retry_count
);
  import code_pkg::*;

  // One counter serves both the inter-digit gap and the WAIT timer.
  localparam int CNT_MAX_A = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > 1) ? CNT_MAX_A : 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_IDX     = 3'(NUM_DIGITS - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  logic [2:0]         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  result_t            res_q, res_d;
  logic [DIGIT_W-1:0] number_q, number_d;
  logic               number_valid_q, number_valid_d;
  logic               lock_rst_q, lock_rst_d;
  logic               done_q, done_d;
  logic [DIGIT_W-1:0] code_digit;
  logic               status_fail;

  // Code is only writable while no attempt is in flight.
  code_store #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (load_en && !busy),
    .wr_idx   (load_idx),
    .wr_digit (load_digit),
    .rd_idx   (idx_d),
    .rd_digit (code_digit)
  );

  assign status_fail = (lock_status == ST_PARTIAL) || (lock_status == ST_ERROR);

  // FSM next-state, digit index, shared counter and run result.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LRST;
          res_d   = '0;
        end
      end
      S_LRST: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        cnt_d = '0;
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_WAIT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The lock's display lags by one cycle, so the first WAIT cycle
        // (cnt_q == 0) still shows the previous attempt and is ignored.
        if ((cnt_q != '0) && (lock_status == ST_SUCCESS)) begin
          state_d       = S_DONE;
          res_d.success = 1'b1;
        end else if (((cnt_q != '0) && status_fail) || (cnt_q == TIMEOUT_LAST)) begin
          if (res_q.retry_count < RETRY_MAX) begin
            res_d.retry_count = res_q.retry_count + 2'd1;
            state_d           = S_LRST;
          end else begin
            state_d    = S_DONE;
            res_d.fail = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state so they line up
  // with the state they belong to.
  always_comb begin
    number_valid_d = (state_d == S_SEND);
    number_d       = (state_d == S_SEND) ? code_digit : number_q;
    lock_rst_d     = (state_d == S_LRST);
    done_d         = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State and output registers; reset aborts any run without a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      res_q          <= '0;
      number_q       <= '0;
      number_valid_q <= 1'b0;
      lock_rst_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      res_q          <= res_d;
      number_q       <= number_d;
      number_valid_q <= number_valid_d;
      lock_rst_q     <= lock_rst_d;
      done_q         <= done_d;
    end
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign number       = number_q;
  assign number_valid = number_valid_q;
  assign lock_rst     = lock_rst_q;
  assign done         = done_q;
  assign success      = res_q.success;
  assign fail         = res_q.fail;
  assign retry_count  = res_q.retry_count;

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: one instance with back-to-back digits,
// one with a two-cycle gap between digits.
`timescale 1ns/1ps
module tb_code_sender;
  import code_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, start_g, load_en, load_en_g;
  logic [2:0] load_idx;
  logic [3:0] load_digit;
  logic [1:0] lock_status;

  logic [3:0] number, number_g;
  logic       number_valid, number_valid_g, lock_rst, lock_rst_g;
  logic       busy, busy_g, done, done_g, success, success_g, fail, fail_g;
  logic [1:0] retry_count, retry_count_g;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_code [6];

  always #5 clock = ~clock;

  code_sender dut (
    .clock(clock), .reset(reset), .start(start), .load_en(load_en),
    .load_idx(load_idx), .load_digit(load_digit), .lock_status(lock_status),
    .number(number), .number_valid(number_valid), .lock_rst(lock_rst),
    .busy(busy), .done(done), .success(success), .fail(fail),
    .retry_count(retry_count)
  );

  code_sender #(.GAP_CYCLES(2)) dut_gap (
    .clock(clock), .reset(reset), .start(start_g), .load_en(load_en_g),
    .load_idx(load_idx), .load_digit(load_digit), .lock_status(lock_status),
    .number(number_g), .number_valid(number_valid_g), .lock_rst(lock_rst_g),
    .busy(busy_g), .done(done_g), .success(success_g), .fail(fail_g),
    .retry_count(retry_count_g)
  );

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_default_code;
    exp_code[0] = 4'd5; exp_code[1] = 4'd7; exp_code[2] = 4'd5;
    exp_code[3] = 4'd1; exp_code[4] = 4'd6; exp_code[5] = 4'd4;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({number, number_valid, lock_rst, busy, done, success, fail, retry_count} !== 12'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 000", {number, number_valid, lock_rst, busy, done, success, fail, retry_count});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({number, number_valid, lock_rst, busy, done, success, fail, retry_count} !== 12'd0) begin
      errors++; $display("FAIL idle_outputs: got %h want 000", {number, number_valid, lock_rst, busy, done, success, fail, retry_count});
    end
    checks++;
    if ({number_g, number_valid_g, lock_rst_g, busy_g, done_g, success_g, fail_g, retry_count_g} !== 12'd0) begin
      errors++; $display("FAIL idle_outputs_gap: got %h want 000", {number_g, number_valid_g, lock_rst_g, busy_g, done_g, success_g, fail_g, retry_count_g});
    end
  endtask

  // Start, six digits on cycles 2..7, lock answers success at cycle 10.
  task automatic test_basic;
    set_default_code();
    pulse_start();
    checks++;
    if ({lock_rst, busy, number_valid} !== 3'b110) begin
      errors++; $display("FAIL basic_lrst: got rst/busy/valid=%b want 110", {lock_rst, busy, number_valid});
    end
    for (int c = 2; c <= 7; c++) begin
      tick();
      checks++;
      if ({lock_rst, number_valid, number} !== {2'b01, exp_code[c-2]}) begin
        errors++; $display("FAIL basic_digit c%0d: got rst=%b v=%b n=%0d want rst=0 v=1 n=%0d", c, lock_rst, number_valid, number, exp_code[c-2]);
      end
    end
    tick(); // cycle 8, first WAIT cycle
    checks++;
    if ({number_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL basic_wait: got valid/busy=%b want 01", {number_valid, busy});
    end
    tick(); tick(); // cycle 10
    lock_status = ST_SUCCESS;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_early_done: got %b want 0", done);
    end
    tick(); // cycle 11
    lock_status = ST_WAIT;
    checks++;
    if ({done, success, fail, retry_count, busy} !== 6'b110000) begin
      errors++; $display("FAIL basic_done: got done/succ/fail/retry/busy=%b want 110000", {done, success, fail, retry_count, busy});
    end
    tick();
    checks++;
    if ({done, success} !== 2'b01) begin
      errors++; $display("FAIL basic_hold: got done/succ=%b want 01", {done, success});
    end
  endtask

  // Slot 3 reprogrammed to 9; lock keeps reporting partial, three attempts.
  task automatic test_retry_fail;
    set_default_code();
    exp_code[3] = 4'd9;
    load_en = 1'b1; load_idx = 3'd3; load_digit = 4'd9;
    tick();
    load_en = 1'b0;
    lock_status = ST_PARTIAL;
    pulse_start();
    checks++;
    if ({success, fail, retry_count} !== 4'b0000) begin
      errors++; $display("FAIL retry_cleared: got succ/fail/retry=%b want 0000", {success, fail, retry_count});
    end
    for (int c = 1; c <= 28; c++) begin
      if (c > 1) tick();
      checks++;
      if (lock_rst !== ((c == 1) || (c == 10) || (c == 19))) begin
        errors++; $display("FAIL retry_lock_rst c%0d: got %b", c, lock_rst);
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if ({number_valid, number} !== {1'b1, exp_code[c-2]}) begin
          errors++; $display("FAIL retry_digit c%0d: got v=%b n=%0d want v=1 n=%0d", c, number_valid, number, exp_code[c-2]);
        end
      end
      if (c == 10 || c == 19) begin
        checks++;
        if (retry_count !== ((c == 10) ? 2'd1 : 2'd2)) begin
          errors++; $display("FAIL retry_count c%0d: got %0d", c, retry_count);
        end
      end
      if (c < 28) begin
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL retry_early_done c%0d: got %b want 0", c, done);
        end
      end
    end
    checks++;
    if ({done, fail, success, retry_count, busy} !== 6'b110100) begin
      errors++; $display("FAIL retry_final: got done/fail/succ/retry/busy=%b want 110100", {done, fail, success, retry_count, busy});
    end
    lock_status = ST_WAIT;
    load_en = 1'b1; load_idx = 3'd3; load_digit = 4'd1;
    tick();
    load_en = 1'b0;
  endtask

  // Lock stays silent: each attempt times out after 8 WAIT cycles.
  task automatic test_timeout;
    lock_status = ST_WAIT;
    pulse_start();
    for (int c = 1; c <= 46; c++) begin
      if (c > 1) tick();
      checks++;
      if ({lock_rst, done} !== {((c == 1) || (c == 16) || (c == 31)), (c == 46)}) begin
        errors++; $display("FAIL timeout_seq c%0d: got rst/done=%b", c, {lock_rst, done});
      end
    end
    checks++;
    if ({fail, success, retry_count} !== 4'b1010) begin
      errors++; $display("FAIL timeout_final: got fail/succ/retry=%b want 1010", {fail, success, retry_count});
    end
  endtask

  // Gap instance: valid every 3 cycles, number held during gaps.
  task automatic test_gap;
    set_default_code();
    start_g = 1'b1;
    tick();
    start_g = 1'b0;
    checks++;
    if (lock_rst_g !== 1'b1) begin
      errors++; $display("FAIL gap_lrst: got %b want 1", lock_rst_g);
    end
    for (int c = 2; c <= 19; c++) begin
      tick();
      checks++;
      if ({number_valid_g, number_g} !== {(((c - 2) % 3) == 0), exp_code[(c-2)/3]}) begin
        errors++; $display("FAIL gap_digit c%0d: got v=%b n=%0d want v=%b n=%0d", c, number_valid_g, number_g, (((c - 2) % 3) == 0), exp_code[(c-2)/3]);
      end
    end
    tick(); // cycle 20, first WAIT cycle
    lock_status = ST_SUCCESS;
    tick(); // cycle 21
    checks++;
    if (done_g !== 1'b0) begin
      errors++; $display("FAIL gap_early_done: got %b want 0", done_g);
    end
    tick(); // cycle 22
    lock_status = ST_WAIT;
    checks++;
    if ({done_g, success_g} !== 2'b11) begin
      errors++; $display("FAIL gap_done: got done/succ=%b want 11", {done_g, success_g});
    end
  endtask

  // start and load during a run are ignored; a later run shows the code intact.
  task automatic test_busy_ignore;
    set_default_code();
    for (int run = 0; run < 2; run++) begin
      pulse_start();
      for (int c = 2; c <= 10; c++) begin
        tick();
        if (run == 0 && c == 3) begin
          start = 1'b1; load_en = 1'b1; load_idx = 3'd2; load_digit = 4'hF;
        end
        if (run == 0 && c == 4) begin
          start = 1'b0; load_en = 1'b0;
        end
        if (c == 9) lock_status = ST_SUCCESS;
        checks++;
        if (lock_rst !== 1'b0) begin
          errors++; $display("FAIL busy_restart run%0d c%0d: lock_rst got 1 want 0", run, c);
        end
        if (c <= 7) begin
          checks++;
          if ({number_valid, number} !== {1'b1, exp_code[c-2]}) begin
            errors++; $display("FAIL busy_digit run%0d c%0d: got v=%b n=%0d want n=%0d", run, c, number_valid, number, exp_code[c-2]);
          end
        end
      end
      lock_status = ST_WAIT;
      checks++;
      if ({done, success} !== 2'b11) begin
        errors++; $display("FAIL busy_done run%0d: got done/succ=%b want 11", run, {done, success});
      end
    end
  endtask

  // Out-of-range loads are dropped; load+start together uses the new digit.
  task automatic test_bad_index;
    set_default_code();
    exp_code[0] = 4'hA;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    load_en = 1'b1; load_idx = 3'd7; load_digit = 4'hF;
    tick();
    load_idx = 3'd6;
    tick();
    load_idx = 3'd0; load_digit = 4'hA; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    checks++;
    if (lock_rst !== 1'b1) begin
      errors++; $display("FAIL loadstart_lrst: got %b want 1", lock_rst);
    end
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (c == 9) lock_status = ST_SUCCESS;
      if (c <= 7) begin
        checks++;
        if ({number_valid, number} !== {1'b1, exp_code[c-2]}) begin
          errors++; $display("FAIL badidx_digit c%0d: got v=%b n=%0d want n=%0d", c, number_valid, number, exp_code[c-2]);
        end
      end
    end
    lock_status = ST_WAIT;
    checks++;
    if ({done, success} !== 2'b11) begin
      errors++; $display("FAIL badidx_done: got done/succ=%b want 11", {done, success});
    end
  endtask

  // Reset during the 4th digit: outputs clear, no done, code back to default.
  task automatic test_reset_abort;
    set_default_code();
    pulse_start();
    tick(); tick(); tick(); tick(); // cycle 5, fourth SEND
    checks++;
    if ({number_valid, number} !== {1'b1, exp_code[3]}) begin
      errors++; $display("FAIL abort_pre: got v=%b n=%0d want v=1 n=%0d", number_valid, number, exp_code[3]);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({number, number_valid, lock_rst, busy, done, success, fail, retry_count} !== 12'd0) begin
      errors++; $display("FAIL abort_async: got %h want 000", {number, number_valid, lock_rst, busy, done, success, fail, retry_count});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 1) reset = 1'b0;
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++; $display("FAIL abort_idle c%0d: got done/busy=%b want 00", c, {done, busy});
      end
    end
    pulse_start();
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (c == 9) lock_status = ST_SUCCESS;
      if (c <= 7) begin
        checks++;
        if ({number_valid, number} !== {1'b1, exp_code[c-2]}) begin
          errors++; $display("FAIL abort_digit c%0d: got v=%b n=%0d want n=%0d", c, number_valid, number, exp_code[c-2]);
        end
      end
    end
    lock_status = ST_WAIT;
    checks++;
    if ({done, success} !== 2'b11) begin
      errors++; $display("FAIL abort_done: got done/succ=%b want 11", {done, success});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_g = 1'b0; load_en = 1'b0; load_en_g = 1'b0;
    load_idx = 3'd0; load_digit = 4'd0; lock_status = ST_WAIT;
    test_reset();
    test_basic();
    test_retry_fail();
    test_timeout();
    test_gap();
    test_busy_ignore();
    test_bad_index();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
